rr_enc_arbiter4: RTL and testbench
==================================

// Module: rr_enc_arbiter4
// PURPOSE
//  4-requester round-robin arbiter for the shared 4-to-2 encoder resource.
//  Grants one requester at a time; outputs the grant one-hot and 2-bit encoded
//  index (gnt_idx[1]=e1, gnt_idx[0]=e0 convention). Enforces a hold limit and a
//  1-cycle turnaround between owners. Sits between the request sources and the encoder datapath.
// PARAMETERS
//  HOLD_MAX  8  max cycles one owner may hold the grant (legal 2..255); forced release at limit
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  req        in   4  request lines; req[i] high = requester i wants the resource
//  done       in   1  current owner finished; sampled only in GRANT
//  gnt        out  4  one-hot grant, registered; all-zero when no owner
//  gnt_idx    out  2  encoded owner index, registered; 2'b00 when gnt_valid=0
//  gnt_valid  out  1  high while any grant is active (== |gnt)
//  timeout    out  1  1-cycle pulse when a grant is revoked by HOLD_MAX
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//   ptr=2'd0, hold_cnt=0. Reset mid-grant drops grant in the same instant.
//  States: IDLE, GRANT (2-bit encoded state reg).
//  Priority: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first req[i]=1 wins.
//  IDLE: if |req at edge N -> gnt/gnt_idx/gnt_valid set after edge N, owner=winner,
//   hold_cnt=0, ->GRANT. Latency req->gnt = 1 cycle. If req==0, stay IDLE, outputs 0.
//  GRANT: each edge, release if any of (checked in this priority for timeout flag):
//   a) done=1; b) req[owner]=0; c) hold_cnt==HOLD_MAX-1 (and not a/b) -> timeout=1.
//   On release: gnt=0, gnt_idx=0, gnt_valid=0, ptr=owner+1 (mod 4, 3 wraps to 0),
//   hold_cnt=0, ->IDLE. Otherwise hold_cnt+=1, outputs unchanged.
//  Owner holds at most HOLD_MAX cycles of gnt_valid=1.
//  Turnaround: after any release, gnt_valid=0 for exactly 1 cycle minimum
//   (IDLE cycle) before the next grant; no back-to-back owner switch.
//  Requests from other requesters during GRANT are ignored (non-preemptive).
//  A released owner still requesting ranks lowest next round (ptr moved past it).
//  timeout: asserted only in the cycle following the forced-release edge; else 0.
//  hold_cnt width = 8 bits; never wraps (cleared on release).
//  gnt one-hot invariant: popcount(gnt)<=1 at all times; gnt_idx matches gnt.
//  done while IDLE is ignored. X on req in IDLE is a bench error, not handled.
// TESTING
//  1 rst=1 then release, req=0 for 5 cycles -> gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
//  2 req=4'b0100 from ptr=0 -> next cycle gnt=4'b0100, gnt_idx=2'b10; done pulse ->
//    gnt=0 next cycle, ptr=3.
//  3 req=4'b1111 held, done pulsed 2 cycles after each grant -> owners 0,1,2,3,0
//    (gnt_idx 00,01,10,11,00), 1-cycle gap of gnt_valid=0 between each.
//  4 req=4'b0001 held, done=0, HOLD_MAX=8 -> gnt_valid high exactly 8 cycles,
//    then timeout=1 for 1 cycle, gnt=0; next grant to req 0 after 1-cycle gap.
//  5 owner=2 granted, req[2] drops while req[0]=1 -> release, ptr=3, next grant
//    gnt_idx=2'b00 after 1 idle cycle; timeout stays 0.
//  6 assert rst mid-grant (owner=3, hold_cnt=4) between edges -> gnt=0 immediately;
//    after deassert with req=4'b1000, grant to 3 from ptr=0 on next edge.

Source files
------------

// File: rtl/rr_enc_arbiter4.sv
// 4-way round-robin arbiter feeding the shared encoder: registered one-hot grant plus encoded index, 1-cycle req->gnt.
// Non-preemptive: an owner keeps the grant until done, request drop or HOLD_MAX, then one idle cycle before the next owner.
module rr_enc_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic [3:0] rot_req;
    logic [1:0] off;
    logic [1:0] winner;
    logic       owner_req;
    logic       hit_limit;

    // Rotate requests so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot_req = 4'({req, req} >> ptr_q);
        if (rot_req[0])      off = 2'd0;
        else if (rot_req[1]) off = 2'd1;
        else if (rot_req[2]) off = 2'd2;
        else                 off = 2'd3;
        winner = ptr_q + off;
    end

    assign owner_req = req[idx_q];
    assign hit_limit = (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (done || !owner_req || hit_limit) begin
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_d = !done && owner_req;
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    idx_d     = 2'd0;
                    hold_d    = 8'd0;
                    ptr_d     = idx_q + 2'd1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                idx_d   = 2'd0;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_enc_arbiter4.sv
// Bench for rr_enc_arbiter4: directed scenarios plus randomized traffic against an ownership model.
module tb_rr_enc_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_tmo;

    rr_enc_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_hold  = 0;
                end
            end
        end else if (done || !req[m_owner] || m_hold == HOLD_MAX - 1) begin
            m_tmo   = !done && req[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_hold  = 0;
        end else begin
            m_hold = m_hold + 1;
        end
    endtask

    // Advance one clock: model follows the edge, caller resumes on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0000 || gnt_idx !== 2'b00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got gnt=%b idx=%b vld=%b tmo=%b want all zero",
                         i, gnt, gnt_idx, gnt_valid, timeout);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'b10 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got gnt=%b idx=%b vld=%b want 0100/10/1", gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL single_done got gnt=%b vld=%b tmo=%b want 0000/0/0", gnt, gnt_valid, timeout);
        end
        // Pointer now 3: requester 3 must beat requester 0.
        req = 4'b1001;
        tick();
        total++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'b11) begin
            bad++;
            $display("FAIL single_ptr3 got gnt=%b idx=%b want 1000/11", gnt, gnt_idx);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        int exp_owner [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (gnt !== 4'(1 << exp_owner[n]) || gnt_idx !== 2'(exp_owner[n])) begin
                bad++;
                $display("FAIL rotation_owner n=%0d got gnt=%b idx=%b want owner %0d", n, gnt, gnt_idx, exp_owner[n]);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            total++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                bad++;
                $display("FAIL rotation_gap n=%0d got vld=%b gnt=%b want 0/0000", n, gnt_valid, gnt);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        apply_reset();
        req = 4'b0001;
        tick();
        cnt = 0;
        while (gnt_valid === 1'b1 && cnt < 20) begin
            total++;
            if (timeout !== 1'b0) begin
                bad++;
                $display("FAIL timeout_early cyc=%0d got tmo=%b want 0", cnt, timeout);
            end
            cnt++;
            tick();
        end
        total++;
        if (cnt !== HOLD_MAX) begin
            bad++;
            $display("FAIL timeout_hold_len got %0d cycles want %0d", cnt, HOLD_MAX);
        end
        total++;
        if (timeout !== 1'b1 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL timeout_pulse got tmo=%b gnt=%b want 1/0000", timeout, gnt);
        end
        tick();
        total++;
        if (timeout !== 1'b0 || gnt !== 4'b0001 || gnt_idx !== 2'b00) begin
            bad++;
            $display("FAIL timeout_regrant got tmo=%b gnt=%b idx=%b want 0/0001/00", timeout, gnt, gnt_idx);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_drop();
        apply_reset();
        req = 4'b0100;
        tick();
        tick();
        total++;
        if (gnt_idx !== 2'b10) begin
            bad++;
            $display("FAIL drop_owner got idx=%b want 10", gnt_idx);
        end
        req = 4'b0001;
        tick();
        total++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL drop_release got vld=%b tmo=%b want 0/0", gnt_valid, timeout);
        end
        tick();
        total++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'b00 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL drop_next got gnt=%b idx=%b tmo=%b want 0001/00/0", gnt, gnt_idx, timeout);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_midgrant();
        apply_reset();
        req = 4'b1000;
        tick();
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'b00) begin
            bad++;
            $display("FAIL midreset_drop got gnt=%b vld=%b idx=%b want 0000/0/00", gnt, gnt_valid, gnt_idx);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'b11) begin
            bad++;
            $display("FAIL midreset_regrant got gnt=%b idx=%b want 1000/11", gnt, gnt_idx);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [3:0] exp_gnt;
        logic [1:0] exp_idx;
        int         tmo_seen;
        apply_reset();
        tmo_seen = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            done = ($urandom_range(7) == 0);
            tick();
            exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            exp_idx = (m_owner < 0) ? 2'b00 : 2'(m_owner);
            if (m_tmo) tmo_seen++;
            total++;
            if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_valid !== (m_owner >= 0) || timeout !== m_tmo) begin
                bad++;
                $display("FAIL random cyc=%0d got gnt=%b idx=%b vld=%b tmo=%b want %b/%b/%b/%b",
                         i, gnt, gnt_idx, gnt_valid, timeout, exp_gnt, exp_idx, (m_owner >= 0), m_tmo);
            end
            total++;
            if ($countones(gnt) > 1) begin
                bad++;
                $display("FAIL random_onehot cyc=%0d got gnt=%b want at most one bit", i, gnt);
            end
        end
        $display("random phase: %0d timeouts exercised", tmo_seen);
        done = 1'b0;
        req  = 4'b0000;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_drop();
        test_reset_midgrant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
